bcd_scan_display: RTL
=====================

Name: bcd_scan_display

Overview:
- Downstream consumer of the cascaded 0-9 decade counter stages.
- Takes DIGITS packed BCD digits (each digit is the Q[4:1] of one counter stage) and time-multiplexes them onto a common-anode 7-segment display.
- Provides a per-digit refresh prescaler, frame-consistent snapshotting (no tearing while counters run), leading-zero blanking, invalid-code indication and one anti-ghost blank cycle per slot.

Parameters:
- DIGITS, 4, number of digits scanned (>=1).
- REFRESH_DIV, 50000, clocks per digit slot (>=2); the first clock of each slot is blank.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  scan enable; 0 freezes the scan state.
- bcd  input  4*DIGITS  packed digits; digit k = bcd[4k+3:4k]; digit 0 is least significant.
- blank_lz  input  1  1 = blank leading zeros.
- dp_mask  input  DIGITS  decimal point request per digit; sampled with bcd.
- seg  output  7  segments a..g on bits 0..6; active-low (0 = lit).
- dp  output  1  decimal point; active-low.
- an  output  DIGITS  digit anodes; active-low, at most one low at any time.
- frame_start  output  1  one-cycle pulse when a new snapshot is loaded.

Behaviour:
- State registers:
  - started flag
  - prescaler p, range 0..REFRESH_DIV-1
  - digit index idx, range 0..DIGITS-1
  - shadow registers for bcd and dp_mask
  - frame_start register
- Reset (reset=0, asynchronous, also mid-frame):
  - started=0, p=0, idx=0, shadow=0, frame_start=0.
  - Outputs immediately: an all 1, seg 7'h7F, dp 1.
- First rising edge with reset=1 and enable=1 while started=0:
  - started<=1, p<=0, idx<=0.
  - shadow<=bcd/dp_mask, frame_start<=1.
- Subsequent enabled edges:
  - If p<REFRESH_DIV-1: p<=p+1.
  - Else p<=0 and idx<=idx+1, wrapping DIGITS-1 -> 0.
  - On the wrap to 0: shadow<=current bcd/dp_mask and frame_start<=1. frame_start is 0 on every other edge.
- enable=0: p, idx, shadow and started hold; frame_start<=0; outputs hold their current value (display stays lit).
- Output decode (combinational from registered state; same-cycle, no extra latency):
  - started=0 or p==0 -> an all 1, seg 7'h7F, dp 1 (blank cycle).
  - Otherwise an = all 1 except bit idx = 0, unless digit idx is blanked.
  - Blanked digit: an all 1, seg 7'h7F, dp 1.
- Leading-zero blanking (blank_lz=1):
  - Digit k is blanked if shadow digit k and all higher shadow digits are 0.
  - Digit 0 is never blanked.
  - Evaluated on the shadow, not on live bcd.
- Segment decode of shadow digit (active-low values): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
- Codes 10-15 are invalid: show a dash, seg 7'h3F (g only).
- dp = ~shadow_dp[idx] whenever the digit is shown.
- The live bcd input is never displayed directly; changes appear only after the next frame_start.
- Frame period = DIGITS*REFRESH_DIV enabled clocks.

Test Plan:
All scenarios use DIGITS=4, REFRESH_DIV=4.
1. Reset: hold reset=0 with random bcd/enable -> an=4'hF, seg=7'h7F, dp=1, frame_start=0. Assert reset=0 mid-slot -> same values asynchronously, before the next clk edge.
2. Scan order: bcd=16'h1234, blank_lz=0, enable=1, release reset.
   - Edge 1: frame_start=1, an=F.
   - Edges 2-4: an=E, seg=19 (shows 4).
   - Edge 5: an=F.
   - Edges 6-8: an=D, seg=30.
   - Then an=B, seg=24; then an=7, seg=79.
   - Edge 17: frame_start=1.
3. No tearing: change bcd to 16'h9999 on edge 6 -> digits still show 1,2,3,4 through edge 16; from edge 18, seg=10 on every digit.
4. Leading-zero blanking:
   - bcd=16'h0070, blank_lz=1 -> slots 3 and 2 have an=F.
   - Slot 1: an=D, seg=78. Slot 0: an=E, seg=40.
   - bcd=16'h0000 -> only slot 0 lit, seg=40.
   - bcd=16'h0100 -> slot 2 lit (seg=79), slot 1 lit (seg=40).
5. Invalid code and decimal point: bcd=16'h00A0, dp_mask=4'b0010, blank_lz=0 -> slot 1 seg=3F, dp=0; other slots dp=1.
6. Freeze: deassert enable during slot 2, p=2, for 10 clocks -> an=B and seg held, no frame_start. Re-enable -> slot completes after 1 more edge, then slot 3 blank cycle follows.

Source files
------------

// File: rtl/bcd_scan_display.sv
// Time-multiplexed common-anode 7-segment driver for DIGITS packed BCD digits.
// A frame-wide snapshot of bcd/dp_mask avoids tearing while upstream counters run.
module bcd_scan_display #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [4*DIGITS-1:0]   bcd,
    input  logic                  blank_lz,
    input  logic [DIGITS-1:0]     dp_mask,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_start
);

    localparam int unsigned PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PLAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] ILAST = IW'(DIGITS - 1);

    logic                started_q;
    logic [PW-1:0]       p_q;
    logic [IW-1:0]       idx_q;
    logic [4*DIGITS-1:0] shadow_q;
    logic [DIGITS-1:0]   shadow_dp_q;
    logic                frame_start_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            started_q     <= 1'b0;
            p_q           <= '0;
            idx_q         <= '0;
            shadow_q      <= '0;
            shadow_dp_q   <= '0;
            frame_start_q <= 1'b0;
        end else if (enable) begin
            if (!started_q) begin
                started_q     <= 1'b1;
                p_q           <= '0;
                idx_q         <= '0;
                shadow_q      <= bcd;
                shadow_dp_q   <= dp_mask;
                frame_start_q <= 1'b1;
            end else begin
                frame_start_q <= 1'b0;
                if (p_q != PLAST) begin
                    p_q <= p_q + 1'b1;
                end else begin
                    p_q <= '0;
                    if (idx_q == ILAST) begin
                        // Wrap to digit 0 starts a new frame with a fresh snapshot.
                        idx_q         <= '0;
                        shadow_q      <= bcd;
                        shadow_dp_q   <= dp_mask;
                        frame_start_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
            end
        end else begin
            frame_start_q <= 1'b0;
        end
    end

    assign frame_start = frame_start_q;

    logic [DIGITS-1:0] blanked;
    logic              upper_zero;

    always_comb begin
        blanked    = '0;
        upper_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            upper_zero = upper_zero && (shadow_q[4*k +: 4] == 4'd0);
            blanked[k] = blank_lz && upper_zero;
        end
    end

    logic [3:0]        cur_digit;
    logic              cur_dp;
    logic              cur_blank;
    logic [DIGITS-1:0] sel_n;

    always_comb begin
        cur_digit = 4'd0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        sel_n     = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                cur_digit = shadow_q[4*k +: 4];
                cur_dp    = shadow_dp_q[k];
                cur_blank = blanked[k];
                sel_n[k]  = 1'b0;
            end
        end
    end

    logic [6:0] seg_dec;

    always_comb begin
        case (cur_digit)
            4'd0:    seg_dec = 7'h40;
            4'd1:    seg_dec = 7'h79;
            4'd2:    seg_dec = 7'h24;
            4'd3:    seg_dec = 7'h30;
            4'd4:    seg_dec = 7'h19;
            4'd5:    seg_dec = 7'h12;
            4'd6:    seg_dec = 7'h02;
            4'd7:    seg_dec = 7'h78;
            4'd8:    seg_dec = 7'h00;
            4'd9:    seg_dec = 7'h10;
            default: seg_dec = 7'h3F;
        endcase
    end

    // The p==0 cycle of every slot is dark to suppress ghosting between digits.
    always_comb begin
        an  = '1;
        seg = 7'h7F;
        dp  = 1'b1;
        if (started_q && (p_q != '0) && !cur_blank) begin
            an  = sel_n;
            seg = seg_dec;
            dp  = ~cur_dp;
        end
    end

endmodule
